// File: rtl/mc_seq_pkg.sv
// -----------------------------------------------------------------------------
// mc_seq_pkg
// Shared definitions for the multi-cycle sequencer:
//   - FSM state encoding (also exported on the debug 'state' port)
//   - next-PC select and write-back source encodings
//   - RV32I major opcode constants and the instruction class derived from them
//   - small decode helpers used by the sequencer
// -----------------------------------------------------------------------------
package mc_seq_pkg;

    // Sequencer states; values are visible on the debug port.
    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Next-PC select.
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    // Register-file write-back source.
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // RV32I major opcodes.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Instruction classes the sequencer distinguishes.
    typedef enum logic [3:0] {
        CL_R       = 4'd0,
        CL_IALU    = 4'd1,
        CL_LOAD    = 4'd2,
        CL_STORE   = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_JAL     = 4'd5,
        CL_JALR    = 4'd6,
        CL_LUI     = 4'd7,
        CL_AUIPC   = 4'd8,
        CL_ILLEGAL = 4'd9
    } iclass_t;

    // Map an opcode to its class; anything unrecognised is illegal.
    function automatic iclass_t op_class(input logic [6:0] op);
        iclass_t cls;
        case (op)
            OP_R:      cls = CL_R;
            OP_IALU:   cls = CL_IALU;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            OP_JALR:   cls = CL_JALR;
            OP_LUI:    cls = CL_LUI;
            OP_AUIPC:  cls = CL_AUIPC;
            default:   cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Only BEQ and BNE are resolved here; other funct3 values fall through.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mc_seq_ctrl_timer.sv
// -----------------------------------------------------------------------------
// mc_wait_timer
// Wait-state timer for the memory handshakes. Counts cycles in which a
// request is outstanding and ready is low; flags expiry on the cycle in which
// the count would reach its all-ones limit while ready is still low.
//   clk     in   rising-edge clock
//   rstn    in   asynchronous active-low reset
//   clear   in   restart the count (asserted on entry to a waiting state)
//   active  in   a request is outstanding this cycle
//   ready   in   the addressed memory answers this cycle
//   expired out  limit reached with ready low (combinational)
// -----------------------------------------------------------------------------
module mc_wait_timer #(
    parameter int WAIT_W = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam logic [WAIT_W-1:0] CNT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] CNT_MAX  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    logic [WAIT_W-1:0] count_r;

    // Wait-cycle counter; saturates so it can never wrap back into range.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (active && !ready && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // The increment taking place this cycle is the one that hits the limit;
    // a ready in the same cycle takes priority.
    assign expired = active & ~ready & (count_r == CNT_LAST);

endmodule

// File: rtl/mc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mc_seq_ctrl
// Multi-cycle sequencer: walks each instruction through FETCH, DECODE, EXEC,
// MEM and WB and gates every architectural update (PC, IR, RF, data memory).
// Requests are Moore (asserted for the whole waiting state); the enables that
// complete a handshake are Mealy on the ready input.
//   clk, rstn                 clock, asynchronous active-low reset
//   Op, Funct3, Zero          IR opcode, IR funct3, ALU zero flag
//   imem_req / imem_ready     instruction fetch handshake
//   dmem_req, dmem_we / dmem_ready  data access handshake
//   pc_we, ir_we, rf_we       state update enables
//   npc_op, wd_sel            next-PC select, write-back source
//   retire, illegal           one-cycle completion / skipped-opcode pulses
//   bus_err                   sticky memory timeout flag
//   state                     current FSM state (debug)
// -----------------------------------------------------------------------------
module mc_seq_ctrl
    import mc_seq_pkg::*;
#(
    parameter int WAIT_W = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Zero,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       rf_we,
    output logic [2:0] npc_op,
    output logic [1:0] wd_sel,
    output logic       retire,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    state_t      state_r;
    state_t      nxt_s;
    logic        bus_err_r;
    iclass_t     cls_s;
    logic        expired_s;
    logic        tmr_clear_s;
    logic        tmr_active_s;
    logic        tmr_ready_s;
    logic        set_err_s;

    logic        imem_req_s;
    logic        dmem_req_s;
    logic        dmem_we_s;
    logic        pc_we_s;
    logic        ir_we_s;
    logic        rf_we_s;
    logic [2:0]  npc_op_s;
    logic [1:0]  wd_sel_s;
    logic        retire_s;
    logic        illegal_s;

    assign cls_s = op_class(Op);

    // The timer watches whichever memory the current state is waiting on and
    // restarts whenever a waiting state is freshly entered.
    assign tmr_active_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
    assign tmr_ready_s  = (state_r == ST_FETCH) ? imem_ready : dmem_ready;
    assign tmr_clear_s  = ((nxt_s == ST_FETCH) || (nxt_s == ST_MEM)) && (nxt_s != state_r);

    mc_wait_timer #(
        .WAIT_W (WAIT_W)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (tmr_clear_s),
        .active  (tmr_active_s),
        .ready   (tmr_ready_s),
        .expired (expired_s)
    );

    // Next-state and output decode; everything defaults to inactive.
    always_comb begin
        nxt_s      = state_r;
        set_err_s  = 1'b0;
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        pc_we_s    = 1'b0;
        ir_we_s    = 1'b0;
        rf_we_s    = 1'b0;
        npc_op_s   = NPC_PLUS4;
        wd_sel_s   = WD_ALU;
        retire_s   = 1'b0;
        illegal_s  = 1'b0;

        case (state_r)
            ST_RST: begin
                nxt_s = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_we_s = 1'b1;
                    nxt_s   = ST_DECODE;
                end else if (expired_s) begin
                    set_err_s = 1'b1;
                    nxt_s     = ST_ERR;
                end else begin
                    nxt_s = ST_FETCH;
                end
            end

            ST_DECODE: begin
                // Unsupported opcodes are skipped by stepping the PC.
                if (cls_s == CL_ILLEGAL) begin
                    illegal_s = 1'b1;
                    pc_we_s   = 1'b1;
                    nxt_s     = ST_FETCH;
                end else begin
                    nxt_s = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (cls_s == CL_BRANCH) begin
                    pc_we_s  = 1'b1;
                    retire_s = 1'b1;
                    nxt_s    = ST_FETCH;
                    if (branch_taken(Funct3, Zero)) begin
                        npc_op_s = NPC_BRANCH;
                    end else begin
                        npc_op_s = NPC_PLUS4;
                    end
                end else if ((cls_s == CL_LOAD) || (cls_s == CL_STORE)) begin
                    nxt_s = ST_MEM;
                end else begin
                    nxt_s = ST_WB;
                end
            end

            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (cls_s == CL_STORE);
                if (dmem_ready) begin
                    if (cls_s == CL_STORE) begin
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        nxt_s    = ST_FETCH;
                    end else begin
                        nxt_s = ST_WB;
                    end
                end else if (expired_s) begin
                    set_err_s = 1'b1;
                    nxt_s     = ST_ERR;
                end else begin
                    nxt_s = ST_MEM;
                end
            end

            ST_WB: begin
                rf_we_s  = 1'b1;
                pc_we_s  = 1'b1;
                retire_s = 1'b1;
                nxt_s    = ST_FETCH;
                case (cls_s)
                    CL_LOAD: begin
                        wd_sel_s = WD_MEM;
                    end
                    CL_JAL: begin
                        wd_sel_s = WD_PC;
                        npc_op_s = NPC_JUMP;
                    end
                    CL_JALR: begin
                        wd_sel_s = WD_PC;
                        npc_op_s = NPC_JALR;
                    end
                    default: begin
                        wd_sel_s = WD_ALU;
                        npc_op_s = NPC_PLUS4;
                    end
                endcase
            end

            ST_ERR: begin
                // Terminal until reset; all enables stay low.
                nxt_s = ST_ERR;
            end

            default: begin
                // Unused encoding: park in the safe terminal state.
                nxt_s = ST_ERR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_RST;
        end else begin
            state_r <= nxt_s;
        end
    end

    // Sticky bus error, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= bus_err_r | set_err_s;
        end
    end

    assign imem_req = imem_req_s;
    assign dmem_req = dmem_req_s;
    assign dmem_we  = dmem_we_s;
    assign pc_we    = pc_we_s;
    assign ir_we    = ir_we_s;
    assign rf_we    = rf_we_s;
    assign npc_op   = npc_op_s;
    assign wd_sel   = wd_sel_s;
    assign retire   = retire_s;
    assign illegal  = illegal_s;
    assign bus_err  = bus_err_r;
    assign state    = state_r;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Bench for mc_seq_ctrl: a driver issues instructions with chosen memory wait
// counts and pushes the expected per-instruction summary into a queue; a
// monitor gathers what the DUT did over each instruction and compares.
module tb_mc_seq_ctrl;

    localparam int WAIT_W = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Zero;
    logic       imem_req, imem_ready;
    logic       dmem_req, dmem_we, dmem_ready;
    logic       pc_we, ir_we, rf_we;
    logic [2:0] npc_op;
    logic [1:0] wd_sel;
    logic       retire, illegal, bus_err;
    logic [2:0] state;

    always #5 clk = ~clk;

    mc_seq_ctrl #(.WAIT_W(WAIT_W)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct3(Funct3), .Zero(Zero),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
        .npc_op(npc_op), .wd_sel(wd_sel), .retire(retire), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    typedef struct {
        int lat; int n_imem; int n_irwe; int n_dmem; int n_dmemwe;
        int n_rfwe; int n_retire; int n_illegal; int npc; int wd;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected per-instruction behaviour, from the class timing rules.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic z, input int w1, input int w2);
        exp_t e;
        e = '{default: 0};
        e.n_imem = w1 + 1;
        e.n_irwe = 1;
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                e.lat = 4 + w1; e.n_rfwe = 1; e.n_retire = 1;
            end
            7'b1101111: begin
                e.lat = 4 + w1; e.n_rfwe = 1; e.n_retire = 1; e.wd = 2; e.npc = 2;
            end
            7'b1100111: begin
                e.lat = 4 + w1; e.n_rfwe = 1; e.n_retire = 1; e.wd = 2; e.npc = 4;
            end
            7'b0000011: begin
                e.lat = 5 + w1 + w2; e.n_dmem = w2 + 1; e.n_rfwe = 1;
                e.n_retire = 1; e.wd = 1;
            end
            7'b0100011: begin
                e.lat = 4 + w1 + w2; e.n_dmem = w2 + 1; e.n_dmemwe = w2 + 1;
                e.n_retire = 1;
            end
            7'b1100011: begin
                e.lat = 3 + w1; e.n_retire = 1;
                e.npc = (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z)) ? 1 : 0;
            end
            default: begin
                e.lat = 2 + w1; e.n_illegal = 1;
            end
        endcase
        return e;
    endfunction

    // Drive one instruction: ready answers after w1/w2 request cycles; while a
    // request is low the ready lines carry random noise that must be ignored.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int w1, input int w2);
        int icnt = 0;
        int dcnt = 0;
        bit done = 1'b0;
        sb_q.push_back(model(op, f3, z, w1, w2));
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            Op = op; Funct3 = f3; Zero = z;
            imem_ready = imem_req ? (icnt == w1) : 1'($urandom_range(0, 1));
            dmem_ready = dmem_req ? (dcnt == w2) : 1'($urandom_range(0, 1));
            if (imem_req) icnt++;
            if (dmem_req) dcnt++;
            #1;
            if (pc_we) done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL instr_end: got no pc_we within 100 cycles, required one (op=%b)", op);
        end
        @(posedge clk);
    endtask

    // Monitor: accumulate activity per instruction, compare when it ends.
    int   cyc, ni, nir, nd, ndw, nrf, nret, nill;
    bit   in_i = 1'b0;
    exp_t e_m;
    initial forever begin
        @(negedge clk); #2;
        if (!mon_en) begin
            in_i = 1'b0;
        end else begin
            if (imem_req && !in_i) begin
                in_i = 1'b1; cyc = 0; ni = 0; nir = 0; nd = 0; ndw = 0;
                nrf = 0; nret = 0; nill = 0;
            end
            if (in_i) begin
                cyc++;
                if (imem_req) ni++;
                if (ir_we)    nir++;
                if (dmem_req) nd++;
                if (dmem_we)  ndw++;
                if (rf_we)    nrf++;
                if (retire)   nret++;
                if (illegal)  nill++;
                if (pc_we) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sb_underflow: got pc_we with no expected instruction");
                    end else begin
                        e_m = sb_q.pop_front();
                        chk("latency",  cyc,    e_m.lat);
                        chk("imem_req_cycles", ni, e_m.n_imem);
                        chk("ir_we_cycles", nir, e_m.n_irwe);
                        chk("dmem_req_cycles", nd, e_m.n_dmem);
                        chk("dmem_we_cycles", ndw, e_m.n_dmemwe);
                        chk("rf_we_cycles", nrf, e_m.n_rfwe);
                        chk("retire_cycles", nret, e_m.n_retire);
                        chk("illegal_cycles", nill, e_m.n_illegal);
                        chk("npc_op", npc_op, e_m.npc);
                        chk("wd_sel", wd_sel, e_m.wd);
                    end
                    in_i = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required end of test");
        $fatal(1, "watchdog");
    end

    logic [6:0] legal_ops [9];
    logic [6:0] rop;
    int         nf, nhold;

    initial begin
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        rstn = 1'b0; Op = 7'd0; Funct3 = 3'd0; Zero = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;

        // Reset: every output low even with ready inputs high.
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs",
            {imem_req, dmem_req, dmem_we, pc_we, ir_we, rf_we, npc_op, wd_sel,
             retire, illegal, bus_err}, 0);
        chk("reset_state", state, 0);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        mon_en = 1'b1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("state_after_reset", state, 1);

        // Directed instructions.
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0);   // ADD, zero wait
        run_instr(7'b0000011, 3'd2, 1'b0, 0, 3);   // LOAD, 3 dmem waits
        run_instr(7'b1100011, 3'd0, 1'b1, 0, 0);   // BEQ taken
        run_instr(7'b1100011, 3'd0, 1'b0, 0, 0);   // BEQ not taken
        run_instr(7'b1100011, 3'd1, 1'b0, 1, 0);   // BNE taken
        run_instr(7'b1100011, 3'd4, 1'b1, 0, 0);   // other funct3: not taken
        run_instr(7'b1100111, 3'd0, 1'b0, 0, 0);   // JALR
        run_instr(7'b1111111, 3'd0, 1'b0, 0, 0);   // illegal
        run_instr(7'b0100011, 3'd2, 1'b0, 2, 1);   // STORE
        run_instr(7'b1101111, 3'd0, 1'b0, 0, 0);   // JAL
        run_instr(7'b0000011, 3'd0, 1'b0, 14, 14); // longest waits short of timeout
        run_instr(7'b0110111, 3'd0, 1'b0, 0, 0);   // LUI
        run_instr(7'b0010111, 3'd0, 1'b0, 1, 0);   // AUIPC
        run_instr(7'b0010011, 3'd0, 1'b0, 0, 0);   // I-ALU

        // Random instruction stream.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) == 0) rop = 7'($urandom);
            else rop = legal_ops[$urandom_range(0, 8)];
            run_instr(rop, 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), $urandom_range(0, 4));
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        mon_en = 1'b0;

        // Asynchronous reset in FETCH drops the request immediately.
        imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk); #3;
        chk("fetch_req_before_reset", imem_req, 1);
        rstn = 1'b0;
        #1;
        chk("async_reset_req", imem_req, 0);
        chk("async_reset_state", state, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("fetch_after_release", state, 1);

        // Timeout: imem_ready held low for the whole fetch.
        nf = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #2;
            if ((state == 3'd1) && imem_req) nf++;
        end
        chk("fetch_wait_cycles", nf, 15);
        chk("bus_err_before_limit", bus_err, 0);
        @(negedge clk); #2;
        chk("err_state", state, 6);
        chk("bus_err_set", bus_err, 1);
        chk("err_req_dropped", imem_req, 0);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        nhold = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #2;
            if ((state == 3'd6) && bus_err &&
                ({imem_req, dmem_req, dmem_we, pc_we, ir_we, rf_we, retire, illegal} == 8'd0))
                nhold++;
        end
        chk("err_hold_cycles", nhold, 20);

        // Reset pulse leaves ERR and clears the sticky flag.
        @(negedge clk); #3;
        rstn = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("err_reset_state", state, 0);
        chk("err_reset_bus_err", bus_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("fetch_after_err_reset", state, 1);
        chk("bus_err_stays_clear", bus_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
